// File: rtl/riscv_decode_pkg.sv
// Shared decode definitions: RV32I major opcodes, instruction-class flags,
// the decoded entry held by the skid buffer, and the buffer occupancy states.
package riscv_decode_pkg;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;

    typedef struct packed {
        logic r_type;
        logic i_type;
        logic store;
        logic branch;
        logic load;
        logic jalr;
        logic jal;
        logic lui;
        logic illegal;
    } instr_class_t;

    // The PC is kept outside this struct so its width can stay a module parameter.
    typedef struct packed {
        logic [31:0]  instr;
        instr_class_t cls;
        logic [4:0]   rd;
        logic [4:0]   rs1;
        logic [4:0]   rs2;
        logic [2:0]   funct3;
        logic [6:0]   funct7;
    } decoded_entry_t;

    localparam int ENTRY_W = $bits(decoded_entry_t);

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_t;

    function automatic logic is_32bit_encoding(input logic [31:0] instr);
        return instr[1:0] == 2'b11;
    endfunction

endpackage

// File: rtl/opcode_class_decode.sv
// Purely combinational instruction-class decode and register/funct field
// extraction, producing one packed decoded entry per instruction word.
module opcode_class_decode
    import riscv_decode_pkg::*;
(
    input  logic [31:0]        i_instr,
    output logic [ENTRY_W-1:0] o_entry
);

    instr_class_t   w_cls;
    decoded_entry_t w_entry;

    always_comb begin
        w_cls = '0;
        if (!is_32bit_encoding(i_instr)) begin
            w_cls.illegal = 1'b1;
        end else begin
            case (i_instr[6:0])
                OPC_R:      w_cls.r_type  = 1'b1;
                OPC_I:      w_cls.i_type  = 1'b1;
                OPC_LOAD:   w_cls.load    = 1'b1;
                OPC_STORE:  w_cls.store   = 1'b1;
                OPC_BRANCH: w_cls.branch  = 1'b1;
                OPC_JALR:   w_cls.jalr    = 1'b1;
                OPC_JAL:    w_cls.jal     = 1'b1;
                OPC_LUI:    w_cls.lui     = 1'b1;
                default:    w_cls.illegal = 1'b1;
            endcase
        end
    end

    // Fields are sliced for every class; consumers ignore the ones they do not use.
    always_comb begin
        w_entry        = '0;
        w_entry.instr  = i_instr;
        w_entry.cls    = w_cls;
        w_entry.rd     = i_instr[11:7];
        w_entry.rs1    = i_instr[19:15];
        w_entry.rs2    = i_instr[24:20];
        w_entry.funct3 = i_instr[14:12];
        w_entry.funct7 = i_instr[31:25];
    end

    assign o_entry = w_entry;

endmodule

// File: rtl/type_decode_stage.sv
// Decode stage: classifies each fetched instruction, then holds decoded entries
// in a 2-deep skid buffer with a registered upstream ready.
module type_decode_stage
    import riscv_decode_pkg::*;
#(
    parameter int PC_W = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            flush_i,

    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [31:0]     in_instr_i,
    input  logic [PC_W-1:0] in_pc_i,

    output logic            out_valid_o,
    input  logic            out_ready_i,
    output logic [31:0]     out_instr_o,
    output logic [PC_W-1:0] out_pc_o,

    output logic            r_type_o,
    output logic            i_type_o,
    output logic            store_o,
    output logic            branch_o,
    output logic            load_o,
    output logic            jalr_o,
    output logic            jal_o,
    output logic            lui_o,
    output logic            illegal_o,
    output logic [4:0]      rd_o,
    output logic [4:0]      rs1_o,
    output logic [4:0]      rs2_o,
    output logic [2:0]      funct3_o,
    output logic [6:0]      funct7_o,

    output logic [1:0]      dbg_state_o
);

    // Handshake: a beat moves on a rising edge where valid and ready are both 1;
    // valid never waits on ready, and ready here is a register (low while FULL).

    skid_state_t          r_state;
    skid_state_t          w_state_nxt;
    logic                 r_in_ready;
    decoded_entry_t       r_ent0;
    decoded_entry_t       r_ent1;
    logic [PC_W-1:0]      r_pc0;
    logic [PC_W-1:0]      r_pc1;

    logic [ENTRY_W-1:0]   w_dec_bits;
    decoded_entry_t       w_dec;
    logic                 w_out_valid;
    logic                 w_push;
    logic                 w_pop;
    decoded_entry_t       w_out;
    logic [PC_W-1:0]      w_out_pc;

    opcode_class_decode u_decode (
        .i_instr (in_instr_i),
        .o_entry (w_dec_bits)
    );

    assign w_dec       = decoded_entry_t'(w_dec_bits);
    assign w_out_valid = (r_state != ST_EMPTY);
    assign w_push      = in_valid_i & r_in_ready & ~flush_i;
    assign w_pop       = w_out_valid & out_ready_i;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= ST_EMPTY;
            r_in_ready <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_in_ready <= (w_state_nxt != ST_FULL);
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (flush_i) begin
            w_state_nxt = ST_EMPTY;
        end else begin
            case (r_state)
                ST_EMPTY: if (w_push) w_state_nxt = ST_ONE;
                ST_ONE: begin
                    if (w_push && !w_pop)      w_state_nxt = ST_FULL;
                    else if (w_pop && !w_push) w_state_nxt = ST_EMPTY;
                end
                ST_FULL:  if (w_pop) w_state_nxt = ST_ONE;
                default:  w_state_nxt = ST_EMPTY;
            endcase
        end
    end

    // Slot 0 is always the oldest entry; slot 1 only fills behind it and
    // shifts forward when slot 0 drains.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ent0 <= '0;
            r_ent1 <= '0;
            r_pc0  <= '0;
            r_pc1  <= '0;
        end else if (!flush_i) begin
            case (r_state)
                ST_EMPTY: begin
                    if (w_push) begin
                        r_ent0 <= w_dec;
                        r_pc0  <= in_pc_i;
                    end
                end
                ST_ONE: begin
                    if (w_push && w_pop) begin
                        r_ent0 <= w_dec;
                        r_pc0  <= in_pc_i;
                    end else if (w_push) begin
                        r_ent1 <= w_dec;
                        r_pc1  <= in_pc_i;
                    end
                end
                ST_FULL: begin
                    if (w_pop) begin
                        r_ent0 <= r_ent1;
                        r_pc0  <= r_pc1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_out    = '0;
        w_out_pc = '0;
        if (w_out_valid) begin
            w_out    = r_ent0;
            w_out_pc = r_pc0;
        end
    end

    assign in_ready_o  = r_in_ready;
    assign out_valid_o = w_out_valid;
    assign out_instr_o = w_out.instr;
    assign out_pc_o    = w_out_pc;
    assign r_type_o    = w_out.cls.r_type;
    assign i_type_o    = w_out.cls.i_type;
    assign store_o     = w_out.cls.store;
    assign branch_o    = w_out.cls.branch;
    assign load_o      = w_out.cls.load;
    assign jalr_o      = w_out.cls.jalr;
    assign jal_o       = w_out.cls.jal;
    assign lui_o       = w_out.cls.lui;
    assign illegal_o   = w_out.cls.illegal;
    assign rd_o        = w_out.rd;
    assign rs1_o       = w_out.rs1;
    assign rs2_o       = w_out.rs2;
    assign funct3_o    = w_out.funct3;
    assign funct7_o    = w_out.funct7;
    assign dbg_state_o = r_state;

endmodule
